// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared state encoding, widths and address decode helper for apb_slave_bridge
package apb_slave_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_REQ  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH     = DEF_DATA_WIDTH / 8;

  // Backend port index lives in the top region_bits of the byte address.
  function automatic int unsigned port_index(input logic [31:0] addr,
                                             input int unsigned addr_width,
                                             input int unsigned region_bits);
    logic [31:0] mask;
    mask = (32'd1 << region_bits) - 32'd1;
    return (addr >> (addr_width - region_bits)) & mask;
  endfunction

endpackage

// File: rtl/apb_slave_timer.sv
// rtl/apb_slave_timer.sv - wait-state down-counter and backend timeout up-counter
module apb_slave_timer #(
  parameter logic [3:0]  WAIT_INIT = 4'd0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic wait_en,
  input  logic to_en,
  input  logic clear,
  output logic wait_done,
  output logic timeout
);

  localparam int unsigned   TW      = 16;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
      to_cnt_d   = '0;
    end else begin
      if (load) begin
        wait_cnt_d = WAIT_INIT;
      end else if (wait_en && (wait_cnt_q != '0)) begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end
      if (to_en) begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign wait_done = (wait_cnt_q == '0);
  assign timeout   = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

endmodule

// File: rtl/apb_slave_bridge.sv
// rtl/apb_slave_bridge.sv - APB4 completer fanning transfers out to per-region register backends
module apb_slave_bridge
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned REGION_BITS = 2,
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned MIN_WAIT    = 1,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                              pclk,
  input  logic                              prst_n,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [DATA_WIDTH/8-1:0]           pstrb,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pready,
  output logic                              pslverr,
  output logic [NUM_PORTS-1:0]              be_req,
  output logic                              be_wr,
  output logic [ADDR_WIDTH-REGION_BITS-1:0] be_addr,
  output logic [DATA_WIDTH-1:0]             be_wdata,
  output logic [DATA_WIDTH/8-1:0]           be_strb,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   be_rdata,
  input  logic [NUM_PORTS-1:0]              be_ack,
  input  logic [NUM_PORTS-1:0]              be_err
);

  localparam int unsigned LW        = ADDR_WIDTH - REGION_BITS;
  localparam int unsigned SW        = DATA_WIDTH / 8;
  localparam logic [3:0]  WAIT_INIT = (MIN_WAIT == 0) ? 4'd0 : 4'(MIN_WAIT - 1);

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   sel_q, sel_d;
  logic [NUM_PORTS-1:0]   be_req_q, be_req_d;
  logic                   be_wr_q, be_wr_d;
  logic [LW-1:0]          be_addr_q, be_addr_d;
  logic [DATA_WIDTH-1:0]  be_wdata_q, be_wdata_d;
  logic [SW-1:0]          be_strb_q, be_strb_d;
  logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;

  int unsigned            addr_idx;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   sel_ack, sel_err;
  logic                   wait_done, timeout;

  assign addr_idx = port_index(32'(paddr), ADDR_WIDTH, REGION_BITS);
  assign sel_ack  = |(be_ack & sel_q);
  assign sel_err  = |(be_err & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (sel_q[p]) sel_rdata = sel_rdata | be_rdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    be_wr_d    = be_wr_q;
    be_addr_d  = be_addr_q;
    be_wdata_d = be_wdata_q;
    be_strb_d  = be_strb_q;
    prdata_d   = prdata_q;
    pslverr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          sel_d      = NUM_PORTS'(32'd1 << addr_idx);
          be_wr_d    = pwrite;
          be_addr_d  = paddr[LW-1:0];
          be_wdata_d = pwdata;
          be_strb_d  = pstrb;
          if (addr_idx >= NUM_PORTS || (!pwrite && pstrb != '0)) begin
            state_d   = ST_RESP;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (pwrite && pstrb == '0) begin
            state_d  = ST_RESP;
            prdata_d = '0;
          end else if (MIN_WAIT > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_WAIT: begin
        if (!psel)          state_d = ST_IDLE;
        else if (wait_done) state_d = ST_REQ;
      end
      ST_REQ: begin
        // Abort wins over a same-cycle ack: the requester has already gone away.
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          state_d   = ST_RESP;
          prdata_d  = be_wr_q ? '0 : sel_rdata;
          pslverr_d = sel_err;
        end else if (timeout) begin
          state_d   = ST_RESP;
          prdata_d  = '0;
          pslverr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    be_req_d = (state_d == ST_REQ) ? sel_d : '0;
    pready_d = (state_d == ST_RESP);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      be_req_q   <= '0;
      be_wr_q    <= 1'b0;
      be_addr_q  <= '0;
      be_wdata_q <= '0;
      be_strb_q  <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      be_req_q   <= be_req_d;
      be_wr_q    <= be_wr_d;
      be_addr_q  <= be_addr_d;
      be_wdata_q <= be_wdata_d;
      be_strb_q  <= be_strb_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
    end
  end

  apb_slave_timer #(
    .WAIT_INIT (WAIT_INIT),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk       (pclk),
    .rst_n     (prst_n),
    .load      ((state_q == ST_IDLE) && (state_d == ST_WAIT)),
    .wait_en   (state_q == ST_WAIT),
    .to_en     (state_q == ST_REQ),
    .clear     ((state_q != ST_IDLE) && (state_d == ST_IDLE)),
    .wait_done (wait_done),
    .timeout   (timeout)
  );

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign be_req   = be_req_q;
  assign be_wr    = be_wr_q;
  assign be_addr  = be_addr_q;
  assign be_wdata = be_wdata_q;
  assign be_strb  = be_strb_q;

endmodule

// File: doc/apb_slave_bridge.md
Name: apb_slave_bridge

Overview:
Parametrised APB4 completer that decodes each transfer to one of NUM_PORTS register-file backends via a registered request/acknowledge handshake. It inserts a programmable minimum of wait states and enforces a backend timeout. It reports PSLVERR for unmapped regions, illegal read strobes, backend errors and timeouts. It sits between the APB interconnect and per-function register blocks, one bridge per peripheral.

Parameters:
ADDR_WIDTH, 12, paddr width in bits
DATA_WIDTH, 32, data width in bits; multiple of 8
REGION_BITS, 2, top paddr bits used as port index
NUM_PORTS, 4, number of backend ports; 1..2**REGION_BITS
MIN_WAIT, 1, wait cycles inserted before a backend request; 0..15
TIMEOUT, 16, max REQ cycles before error; 0 disables the timeout

Ports:
pclk  in  1  APB clock, rising edge
prst_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1 = write
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte strobes
prdata  out  DATA_WIDTH  read data, registered
pready  out  1  transfer complete, registered
pslverr  out  1  error response, valid only with pready
be_req  out  NUM_PORTS  one-hot backend request, held until ack, timeout or abort
be_wr  out  1  backend write
be_addr  out  ADDR_WIDTH-REGION_BITS  region-local address
be_wdata  out  DATA_WIDTH  captured pwdata
be_strb  out  DATA_WIDTH/8  captured pstrb
be_rdata  in  NUM_PORTS*DATA_WIDTH  per-port read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
be_ack  in  NUM_PORTS  per-port acknowledge, sampled only in REQ
be_err  in  NUM_PORTS  per-port error, qualified by be_ack

Behaviour:
- Single clock pclk; reset asynchronous, active-low (prst_n).
- Reset values:
  - State is IDLE.
  - prdata=0, pready=0, pslverr=0.
  - be_req=0, be_wr=0, be_addr=0, be_wdata=0, be_strb=0.
  - Both counters are 0.
- States: IDLE, WAIT, REQ, RESP.
- IDLE:
  - A setup phase is psel=1 with penable=0.
  - On a setup phase, capture pwrite, paddr local bits, pwdata, pstrb and port index = paddr[ADDR_WIDTH-1 -: REGION_BITS].
  - Next state, checked in this order:
    - index >= NUM_PORTS -> RESP, error=1.
    - read with pstrb != 0 -> RESP, error=1.
    - write with pstrb == 0 -> RESP, error=0, no backend request.
    - MIN_WAIT > 0 -> WAIT, wait counter loaded with MIN_WAIT-1.
    - otherwise -> REQ.
- WAIT: wait counter decrements each cycle; when it is 0, go to REQ.
- REQ:
  - be_req[index]=1 and all other be_req bits 0.
  - The timeout counter increments each cycle.
  - be_ack[index]=1: latch be_rdata slice into prdata (reads only; prdata is 0 on writes), latch error=be_err[index], drop be_req, go to RESP.
  - TIMEOUT != 0 and counter == TIMEOUT-1 without ack: drop be_req, prdata=0, error=1, go to RESP.
  - be_ack bits of non-selected ports are ignored.
- RESP:
  - pready=1 and pslverr=error for exactly one cycle.
  - Then go to IDLE; clear pready, pslverr and both counters.
  - prdata holds its value until the next RESP.
- pready is 0 in every state except RESP. The bridge never completes in the setup cycle.
- Latency:
  - Setup phase at cycle T0 with immediate ack gives pready at T0+2+MIN_WAIT.
  - A decode or strobe error gives pready at T0+1.
- Abort: psel=0 while in WAIT or REQ returns the bridge to IDLE next cycle, be_req drops, and no response is produced.
- A new setup phase is accepted in the IDLE cycle that follows RESP, so back-to-back transfers are supported.
- Reset asserted mid-transfer clears all state immediately, including be_req.

Decomposition:
- Package apb_slave_pkg holds:
  - the state enum (IDLE, WAIT, REQ, RESP);
  - the localparam STRB_WIDTH = DATA_WIDTH/8;
  - a function for port index extraction.
- Sub-module apb_slave_timer: a loadable down-counter for wait states plus an up-counter for the timeout. It takes load, enable and clear inputs and outputs wait_done and timeout.

Test Plan:
- Write paddr=0x104 (port 0), pstrb=4'hF, MIN_WAIT=1, be_ack one cycle after be_req -> be_wdata and be_strb match the captured values, be_addr=0x104, pready at setup+4, pslverr=0.
- Read paddr=0x8F0 (port 2), be_rdata slice 2 = 0xDEADBEEF, ack at the first REQ cycle -> prdata=0xDEADBEEF, pready at setup+3, be_req=4'b0100 for exactly one cycle.
- NUM_PORTS=3, read paddr=0xC00 -> no be_req, pready at setup+1, pslverr=1, prdata=0.
- Read with pstrb=4'h1 -> pslverr=1 at setup+1. Write with pstrb=0 -> pslverr=0 at setup+1, no be_req.
- TIMEOUT=16, backend never acks -> be_req high exactly 16 cycles, then pready=1, pslverr=1, prdata=0.
- psel dropped during REQ, then prst_n pulsed during a later WAIT -> be_req falls, all outputs return to reset values, and the next transfer completes normally.
